// File: rtl/fire_pkg.sv
// -----------------------------------------------------------------------------
// fire_pkg
// Shared definitions for the Fire code encoder/decoder path.
// Contents:
//   FIRE_N, FIRE_K, FIRE_R  default codeword, message and parity lengths
//   FIRE_GEN_POLY           g(x) = (x^15+1)(x^9+x^4+1) coefficients below x^R
//   fire_state_e            control state encoding shared by encoder and decoder
// -----------------------------------------------------------------------------
package fire_pkg;

    localparam int FIRE_N = 64;
    localparam int FIRE_K = 40;
    localparam int FIRE_R = FIRE_N - FIRE_K;

    // x^24 + x^19 + x^15 + x^9 + x^4 + 1, leading x^24 term implicit.
    localparam logic [FIRE_R-1:0] FIRE_GEN_POLY = 24'h088211;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        SERIAL = 2'd3
    } fire_state_e;

endpackage

// File: rtl/fire_lfsr.sv
// -----------------------------------------------------------------------------
// fire_lfsr
// Generic R-bit Galois LFSR that divides the serial input stream (MSB first)
// by g(x). After shifting in message m(x), the register holds m(x)*x^R mod g(x).
// Ports:
//   clk     clock
//   rst     asynchronous active-high reset, clears the remainder
//   clear   synchronous clear (wins over shift)
//   shift   advance one bit, consuming bit_in
//   bit_in  next message bit
//   rem     current remainder
// -----------------------------------------------------------------------------
module fire_lfsr
    import fire_pkg::*;
#(
    parameter int            R        = FIRE_R,
    parameter logic [R-1:0]  GEN_POLY = R'(FIRE_GEN_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift,
    input  logic         bit_in,
    output logic [R-1:0] rem
);

    logic [R-1:0] rem_q;
    logic [R-1:0] rem_d;
    logic         fb;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rem_d = rem_q;
        fb    = bit_in ^ rem_q[R-1];
        if (clear) begin
            rem_d = '0;
        end else if (shift) begin
            rem_d = {rem_q[R-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/fire_encoder.sv
// -----------------------------------------------------------------------------
// fire_encoder
// Systematic serial Fire code encoder. A K-bit message is shifted MSB-first
// through fire_lfsr; the codeword {message, parity} is then presented in
// parallel, and optionally serialised MSB-first.
// Build option: define FIRE_ENC_SERIAL_OUT_EN to add the SERIAL state and the
// ser_out/ser_valid ports. Without it, DONE returns straight to IDLE.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      encode request, sampled only in IDLE
//   data_in    K-bit message, latched on an accepted start
//   busy       high in every state except IDLE
//   done       one-cycle pulse when codeword becomes valid
//   count      bits processed in the current phase
//   codeword   {message, parity}, held until the next accepted start
//   ser_out    serial codeword bit (option only)
//   ser_valid  ser_out qualifier (option only)
// -----------------------------------------------------------------------------
module fire_encoder
    import fire_pkg::*;
#(
    parameter int              N        = FIRE_N,
    parameter int              K        = FIRE_K,
    parameter logic [N-K-1:0]  GEN_POLY = FIRE_GEN_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [K-1:0] data_in,
    output logic         busy,
    output logic         done,
    output logic [7:0]   count,
    output logic [N-1:0] codeword
`ifdef FIRE_ENC_SERIAL_OUT_EN
    ,
    output logic         ser_out,
    output logic         ser_valid
`endif
);

    localparam int R = N - K;

    fire_state_e  state_q;
    logic [K-1:0] msg_q;
    logic [7:0]   count_q;
    logic         busy_q;
    logic         done_q;
    logic [N-1:0] codeword_q;
    logic [R-1:0] parity;
    logic [K-1:0] msg_sh;
    logic         lfsr_clear;
    logic         lfsr_shift;

    // Message bit K-1-count selected by shifting instead of a computed index.
    assign msg_sh     = msg_q << count_q;
    assign lfsr_clear = (state_q == IDLE) && start;
    assign lfsr_shift = (state_q == SHIFT);

    fire_lfsr #(
        .R        (R),
        .GEN_POLY (GEN_POLY)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .clear  (lfsr_clear),
        .shift  (lfsr_shift),
        .bit_in (msg_sh[K-1]),
        .rem    (parity)
    );

`ifdef FIRE_ENC_SERIAL_OUT_EN
    logic         ser_out_q;
    logic         ser_valid_q;
    logic [N-1:0] cw_sh;

    assign cw_sh = codeword_q << count_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            codeword_q <= '0;
`ifdef FIRE_ENC_SERIAL_OUT_EN
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        msg_q   <= data_in;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    count_q <= count_q + 8'd1;
                    if (count_q == 8'(K - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    codeword_q <= {msg_q, parity};
                    done_q     <= 1'b1;
                    count_q    <= '0;
`ifdef FIRE_ENC_SERIAL_OUT_EN
                    state_q    <= SERIAL;
`else
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
`endif
                end
`ifdef FIRE_ENC_SERIAL_OUT_EN
                SERIAL: begin
                    // count 0..N-1 emits bits; the extra pass at count==N retires
                    // the last bit so busy stays high while it is on the wire.
                    if (count_q == 8'(N)) begin
                        ser_out_q   <= 1'b0;
                        ser_valid_q <= 1'b0;
                        count_q     <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        ser_out_q   <= cw_sh[N-1];
                        ser_valid_q <= 1'b1;
                        count_q     <= count_q + 8'd1;
                    end
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    count_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign codeword = codeword_q;
`ifdef FIRE_ENC_SERIAL_OUT_EN
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
`endif

endmodule

// File: tb/tb_fire_encoder.sv
// -----------------------------------------------------------------------------
// tb_fire_encoder
// Directed self-checking bench for fire_encoder (default N=64, K=40).
// Expected codewords come from a long-division model and are queued when a
// start is driven, then popped when done is seen.
// -----------------------------------------------------------------------------
module tb_fire_encoder;

    localparam int N = 64;
    localparam int K = 40;
    localparam int R = 24;
    localparam logic [R:0] G_FULL = 25'h1088211;

    logic         clk;
    logic         rst;
    logic         start;
    logic [K-1:0] data_in;
    logic         busy;
    logic         done;
    logic [7:0]   count;
    logic [N-1:0] codeword;
`ifdef FIRE_ENC_SERIAL_OUT_EN
    logic         ser_out;
    logic         ser_valid;
`endif

    fire_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .codeword (codeword)
`ifdef FIRE_ENC_SERIAL_OUT_EN
        ,
        .ser_out  (ser_out),
        .ser_valid(ser_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // m(x)*x^R mod g(x) by plain polynomial long division.
    function automatic logic [R-1:0] model_parity(input logic [K-1:0] m);
        logic [N-1:0] v;
        logic [N-1:0] g;
        v = {m, {R{1'b0}}};
        g = {{(N-R-1){1'b0}}, G_FULL};
        for (int i = N - 1; i >= R; i--) begin
            if (v[i]) v = v ^ (g << (i - R));
        end
        return v[R-1:0];
    endfunction

    // Codeword fed MSB-first into an x^15+1 check register.
    function automatic logic [14:0] check15(input logic [N-1:0] cw);
        logic [14:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            r = {r[13:0], cw[i] ^ r[14]};
        end
        return r;
    endfunction

    function automatic logic [K-1:0] rand_msg();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[K-1:0];
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    // Encode one message; with hammer set, start stays high with changing data
    // until done. Returns the observed codeword.
    task automatic encode(input string tag, input logic [K-1:0] msg, input bit hammer,
                          output logic [N-1:0] cw);
        int  lat;
        bit  got;
        logic [N-1:0] exp_cw;
        wait_idle();
        data_in = msg;
        start   = 1'b1;
        exp_q.push_back({msg, model_parity(msg)});
        lat = 0;
        got = 1'b0;
        cw  = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            lat++;
            if (hammer) data_in = rand_msg();
            else        start   = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {63'd0, got}, 64'd1);
        exp_cw = exp_q.pop_front();
        if (got) begin
            // lat counts negedges from the one after edge 0; done follows edge K+1.
            check({tag, "_latency"}, 64'(lat - 1), 64'(K + 1));
            cw = codeword;
            check({tag, "_codeword"}, cw, exp_cw);
        end
    endtask

    logic [N-1:0] cw_a, cw_b, cw_x, cw_z, cw_1, cw_h, cw_r;
    logic [K-1:0] msg_a, msg_b, msg_h;
    int extra_done;
    int waited;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_count", {56'd0, count}, 64'd0);
        check("rst_codeword", codeword, 64'd0);
`ifdef FIRE_ENC_SERIAL_OUT_EN
        check("rst_ser_valid", {63'd0, ser_valid}, 64'd0);
        check("rst_ser_out", {63'd0, ser_out}, 64'd0);
`endif

        // All-zero message
        encode("zero", '0, 1'b0, cw_z);
        check("zero_literal", cw_z, 64'h0);

        // Single low bit: parity is g(x) without its leading term
        encode("one", 40'h1, 1'b0, cw_1);
        check("one_literal", cw_1, {40'h0000000001, 24'h088211});

`ifdef FIRE_ENC_SERIAL_OUT_EN
        begin
            logic [N-1:0] stream;
            int nv;
            bit first_ok, busy_last, busy_after;
            stream = '0; nv = 0; busy_last = 1'b0; busy_after = 1'b1;
            @(negedge clk);
            first_ok = ser_valid;
            for (int c = 0; c < 100; c++) begin
                if (ser_valid) begin
                    stream    = {stream[N-2:0], ser_out};
                    nv++;
                    busy_last = busy;
                end else if (nv > 0) begin
                    busy_after = busy;
                    break;
                end
                @(negedge clk);
            end
            check("ser_first_valid", {63'd0, first_ok}, 64'd1);
            check("ser_valid_cycles", 64'(nv), 64'(N));
            check("ser_stream", stream, cw_1);
            check("ser_busy_last_bit", {63'd0, busy_last}, 64'd1);
            check("ser_busy_after", {63'd0, busy_after}, 64'd0);
        end
`endif

        // Linearity and x^15+1 divisibility
        msg_a = rand_msg();
        msg_b = rand_msg();
        encode("rand_a", msg_a, 1'b0, cw_a);
        encode("rand_b", msg_b, 1'b0, cw_b);
        encode("rand_axb", msg_a ^ msg_b, 1'b0, cw_x);
        check("parity_linear", {40'd0, cw_x[R-1:0]}, {40'd0, cw_a[R-1:0] ^ cw_b[R-1:0]});
        check("chk15_a", {49'd0, check15(cw_a)}, 64'd0);
        check("chk15_b", {49'd0, check15(cw_b)}, 64'd0);
        check("chk15_axb", {49'd0, check15(cw_x)}, 64'd0);

        // start held high throughout SHIFT: only the first message counts
        msg_h = rand_msg();
        encode("hammer", msg_h, 1'b1, cw_h);
        extra_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("hammer_extra_done", 64'(extra_done), 64'd0);

        // Reset in the middle of SHIFT
        wait_idle();
        data_in = rand_msg();
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        waited  = 0;
        while (count != 8'd20 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("mid_count_reached", 64'(count), 64'd20);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_count", {56'd0, count}, 64'd0);
        check("mid_rst_codeword", codeword, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("mid_rst_no_done", 64'(extra_done), 64'd0);
        encode("after_rst", rand_msg(), 1'b0, cw_r);
        check("chk15_after_rst", {49'd0, check15(cw_r)}, 64'd0);

        wait_idle();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
